// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared types and constants for the SPI front end.
//   spi_mode_t       : {cpol, cpha}, bit order matches the 2-bit `mode` port
//   spi_trk_state_t  : frame tracker FSM states
//   SPI_SYNC_MIN     : smallest synchroniser depth the tracker will build
//   spi_is_sample    : picks the sample edge out of leading/trailing for a mode
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int SPI_SYNC_MIN = 2;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_trk_state_t;

    // CPHA=0 samples on the leading edge, CPHA=1 on the trailing edge.
    function automatic logic spi_is_sample(input spi_mode_t m,
                                           input logic      lead,
                                           input logic      trail);
        return m.cpha ? trail : lead;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// -----------------------------------------------------------------------------
// spi_sync
// Multi-flop synchroniser for one asynchronous level.
//   sysclk  : destination clock
//   sysrst  : asynchronous active-low reset, loads RST_VAL into every stage
//   raw     : asynchronous input level
//   synced  : level after DEPTH flops
// -----------------------------------------------------------------------------
module spi_sync #(
    parameter int   DEPTH   = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic sysclk,
    input  logic sysrst,
    input  logic raw,
    output logic synced
);

    logic [DEPTH-1:0] chain;

    always_ff @(posedge sysclk or negedge sysrst) begin
        if (!sysrst) begin
            chain <= {DEPTH{RST_VAL}};
        end else begin
            chain <= {chain[DEPTH-2:0], raw};
        end
    end

    assign synced = chain[DEPTH-1];

endmodule

// File: rtl/spi_sclk_tracker.sv
// -----------------------------------------------------------------------------
// spi_sclk_tracker
// Brings SPI sclk / cs_n into the sysclk domain, classifies sclk edges by the
// mode latched at frame start and produces strobes and framing pulses for the
// shift register and word FSM downstream.
//   sysclk, sysrst : system clock, asynchronous active-low reset
//   sclk, cs_n     : asynchronous SPI clock and chip select
//   mode           : {CPOL, CPHA}, taken only when a frame opens
//   sample_stb     : pulse per sample edge inside a frame
//   shift_stb      : pulse per shift edge inside a frame
//   bit_cnt        : sample edges in the current word (modulo WORD_LEN)
//   word_done      : pulse with the sample strobe that completes a word
//   frame_active   : high while the FSM is ACTIVE
//   frame_start    : pulse on entry to ACTIVE
//   frame_end      : pulse on exit from ACTIVE
//   partial_word   : with frame_end, 1 when the last word was incomplete
//   trk_state      : FSM state, for debug and assertion binding
// Pipeline: SYNC_STAGES synchroniser flops, a delay flop, registered edge
// flags, registered outputs -- a pulse leaves on the SYNC_STAGES+2'th sysclk
// edge counting the edge that first captured the new input level.
// -----------------------------------------------------------------------------
module spi_sclk_tracker
    import spi_pkg::*;
#(
    parameter int WIDTH_CNT   = 4,
    parameter int WORD_LEN    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 sysclk,
    input  logic                 sysrst,
    input  logic                 sclk,
    input  logic                 cs_n,
    input  logic [1:0]           mode,
    output logic                 sample_stb,
    output logic                 shift_stb,
    output logic [WIDTH_CNT-1:0] bit_cnt,
    output logic                 word_done,
    output logic                 frame_active,
    output logic                 frame_start,
    output logic                 frame_end,
    output logic                 partial_word,
    output spi_trk_state_t       trk_state
);

    localparam int SYNC_DEPTH = (SYNC_STAGES < SPI_SYNC_MIN) ? SPI_SYNC_MIN : SYNC_STAGES;
    localparam logic [WIDTH_CNT-1:0] LAST_BIT = WIDTH_CNT'(WORD_LEN - 1);

    logic sclk_s, cs_s;
    logic sclk_dly, cs_dly;
    logic sclk_rise_q, sclk_fall_q, cs_rise_q, cs_fall_q;
    logic [SYNC_DEPTH-1:0] fill;
    logic armed;

    spi_sync #(.DEPTH(SYNC_DEPTH), .RST_VAL(1'b0)) u_sync_sclk (
        .sysclk (sysclk),
        .sysrst (sysrst),
        .raw    (sclk),
        .synced (sclk_s)
    );

    spi_sync #(.DEPTH(SYNC_DEPTH), .RST_VAL(1'b1)) u_sync_cs (
        .sysclk (sysclk),
        .sysrst (sysrst),
        .raw    (cs_n),
        .synced (cs_s)
    );

    // `fill` marks when the synchroniser holds real samples rather than its
    // reset value; only a genuinely observed high cs_n may arm the tracker,
    // so cs_n held low through reset release cannot open a frame.
    always_ff @(posedge sysclk or negedge sysrst) begin
        if (!sysrst) begin
            sclk_dly    <= 1'b0;
            cs_dly      <= 1'b1;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            cs_rise_q   <= 1'b0;
            cs_fall_q   <= 1'b0;
            fill        <= '0;
            armed       <= 1'b0;
        end else begin
            sclk_dly    <= sclk_s;
            cs_dly      <= cs_s;
            sclk_rise_q <= sclk_s & ~sclk_dly;
            sclk_fall_q <= ~sclk_s & sclk_dly;
            cs_rise_q   <= cs_s & ~cs_dly;
            cs_fall_q   <= ~cs_s & cs_dly;
            fill        <= {fill[SYNC_DEPTH-2:0], 1'b1};
            armed       <= armed | (fill[SYNC_DEPTH-1] & cs_s);
        end
    end

    spi_trk_state_t       state, state_nxt;
    spi_mode_t            mode_q, mode_nxt;
    logic [WIDTH_CNT-1:0] cnt_nxt;
    logic                 sample_nxt, shift_nxt, done_nxt;
    logic                 start_nxt, end_nxt, partial_nxt;
    logic                 lead, trail;

    always_comb begin
        state_nxt   = state;
        mode_nxt    = mode_q;
        cnt_nxt     = bit_cnt;
        sample_nxt  = 1'b0;
        shift_nxt   = 1'b0;
        done_nxt    = 1'b0;
        start_nxt   = 1'b0;
        end_nxt     = 1'b0;
        partial_nxt = 1'b0;
        lead        = mode_q.cpol ? sclk_fall_q : sclk_rise_q;
        trail       = mode_q.cpol ? sclk_rise_q : sclk_fall_q;

        case (state)
            IDLE: begin
                // Clearing here also zeroes the count the cycle after frame_end.
                cnt_nxt = '0;
                if (cs_fall_q && armed) begin
                    state_nxt = ACTIVE;
                    mode_nxt  = spi_mode_t'(mode);
                    start_nxt = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise_q) begin
                    // Any sclk edge in this cycle is dropped; bit_cnt holds so
                    // it can be read alongside frame_end.
                    state_nxt   = IDLE;
                    end_nxt     = 1'b1;
                    partial_nxt = (bit_cnt != '0);
                end else begin
                    sample_nxt = spi_is_sample(mode_q, lead, trail);
                    shift_nxt  = spi_is_sample(mode_q, trail, lead);
                    if (sample_nxt) begin
                        if (bit_cnt == LAST_BIT) begin
                            cnt_nxt  = '0;
                            done_nxt = 1'b1;
                        end else begin
                            cnt_nxt = bit_cnt + WIDTH_CNT'(1);
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge sysrst) begin
        if (!sysrst) begin
            state        <= IDLE;
            mode_q       <= '0;
            bit_cnt      <= '0;
            sample_stb   <= 1'b0;
            shift_stb    <= 1'b0;
            word_done    <= 1'b0;
            frame_start  <= 1'b0;
            frame_end    <= 1'b0;
            partial_word <= 1'b0;
        end else begin
            state        <= state_nxt;
            mode_q       <= mode_nxt;
            bit_cnt      <= cnt_nxt;
            sample_stb   <= sample_nxt;
            shift_stb    <= shift_nxt;
            word_done    <= done_nxt;
            frame_start  <= start_nxt;
            frame_end    <= end_nxt;
            partial_word <= partial_nxt;
        end
    end

    assign frame_active = (state == ACTIVE);
    assign trk_state    = state;

endmodule

// File: tb/tb_spi_sclk_tracker.sv
module tb_spi_sclk_tracker;
    import spi_pkg::*;

    localparam int WIDTH_CNT   = 4;
    localparam int WORD_LEN    = 8;
    localparam int SYNC_STAGES = 2;
    localparam int OW          = WIDTH_CNT + 1;

    // ---------------- clock / reset / DUT ----------------
    logic                 sysclk = 1'b0;
    logic                 sysrst;
    logic                 sclk;
    logic                 cs_n;
    logic [1:0]           mode;
    logic                 sample_stb, shift_stb, word_done;
    logic                 frame_active, frame_start, frame_end, partial_word;
    logic [WIDTH_CNT-1:0] bit_cnt;
    spi_trk_state_t       trk_state;

    always #5 sysclk = ~sysclk;

    spi_sclk_tracker #(
        .WIDTH_CNT   (WIDTH_CNT),
        .WORD_LEN    (WORD_LEN),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_dut (
        .sysclk       (sysclk),
        .sysrst       (sysrst),
        .sclk         (sclk),
        .cs_n         (cs_n),
        .mode         (mode),
        .sample_stb   (sample_stb),
        .shift_stb    (shift_stb),
        .bit_cnt      (bit_cnt),
        .word_done    (word_done),
        .frame_active (frame_active),
        .frame_start  (frame_start),
        .frame_end    (frame_end),
        .partial_word (partial_word),
        .trk_state    (trk_state)
    );

    // ---------------- monitor (only writer of the n_* counters) ----------------
    int             n_sample = 0, n_shift = 0, n_done = 0, n_start = 0, n_end = 0, n_lvl_bad = 0;
    logic           exp_lvl = 1'b1;
    logic           end_partial = 1'b0;
    int             end_cnt = 0;
    logic [OW-1:0]  obs_q[$];
    logic [OW-1:0]  exp_q[$];

    always @(negedge sysclk) begin
        if (sample_stb) begin
            n_sample++;
            if (sclk !== exp_lvl) n_lvl_bad++;
            obs_q.push_back({word_done, bit_cnt});
        end
        if (shift_stb)   n_shift++;
        if (word_done)   n_done++;
        if (frame_start) n_start++;
        if (frame_end) begin
            n_end++;
            end_partial = partial_word;
            end_cnt     = int'(bit_cnt);
        end
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0, n_bad = 0;
    int s_start, s_end, s_shift, s_done, s_lvl, s_obs;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic take_snap();
        s_start = n_start;
        s_end   = n_end;
        s_shift = n_shift;
        s_done  = n_done;
        s_lvl   = n_lvl_bad;
        s_obs   = obs_q.size();
    endtask

    task automatic check_frame(input string tag, input int samples, input int shifts,
                               input int words, input int starts, input int ends,
                               input int partial, input int endcnt);
        int got;
        check({tag, " frame_start count"}, n_start - s_start, starts);
        check({tag, " frame_end count"}, n_end - s_end, ends);
        check({tag, " shift count"}, n_shift - s_shift, shifts);
        check({tag, " word_done count"}, n_done - s_done, words);
        check({tag, " samples on wrong sclk level"}, n_lvl_bad - s_lvl, 0);
        got = obs_q.size() - s_obs;
        check({tag, " sample count"}, got, samples);
        exp_q.delete();
        for (int k = 1; k <= samples; k++)
            exp_q.push_back({((k % WORD_LEN) == 0), WIDTH_CNT'(k % WORD_LEN)});
        for (int k = 0; k < samples && k < got; k++) begin
            logic [OW-1:0] e;
            e = exp_q.pop_front();
            check($sformatf("%s {word_done,bit_cnt} at sample %0d", tag, k + 1),
                  int'(obs_q[s_obs + k]), int'(e));
        end
        if (ends > 0) begin
            check({tag, " partial_word at frame_end"}, int'(end_partial), partial);
            check({tag, " bit_cnt at frame_end"}, end_cnt, endcnt);
        end
        check({tag, " bit_cnt after frame"}, int'(bit_cnt), 0);
        check({tag, " frame_active after frame"}, int'(frame_active), 0);
    endtask

    // ---------------- driver tasks (drive on negedge) ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic open_frame(input logic [1:0] m);
        mode = m;
        sclk = m[1];
        idle(8);
        cs_n = 1'b0;
        idle(8);
        check($sformatf("frame_active in mode %0d frame", m), int'(frame_active), 1);
    endtask

    task automatic pulses(input logic cpol, input int n);
        for (int i = 0; i < n; i++) begin
            sclk = ~cpol;
            idle($urandom_range(5, 7));
            sclk = cpol;
            idle($urandom_range(5, 7));
        end
    endtask

    task automatic close_frame();
        cs_n = 1'b1;
        idle(10);
    endtask

    task automatic run_frame(input logic [1:0] m, input int n, input logic lvl);
        exp_lvl = lvl;
        open_frame(m);
        pulses(m[1], n);
        close_frame();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0] mode;
        int         pulses;
        int         shifts;
        int         words;
        int         partial;
        int         endcnt;
        logic       lvl;      // sclk level seen at each sample strobe
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{2'b00,  8,  8, 1, 0, 0, 1'b1};
        vecs[1] = '{2'b11, 20, 20, 2, 1, 4, 1'b1};
        vecs[2] = '{2'b01,  5,  5, 0, 1, 5, 1'b0};
        vecs[3] = '{2'b10, 16, 16, 2, 0, 0, 1'b0};
        vecs[4] = '{2'b00,  3,  3, 0, 1, 3, 1'b1};

        sysrst = 1'b0;
        sclk   = 1'b0;
        cs_n   = 1'b1;
        mode   = 2'b00;
        idle(3);
        check("reset outputs", int'({sample_stb, shift_stb, word_done, frame_active,
                                     frame_start, frame_end, partial_word, bit_cnt}), 0);
        check("reset state", int'(trk_state), int'(IDLE));
        sysrst = 1'b1;
        idle(6);
        check("post-reset outputs", int'({sample_stb, shift_stb, word_done, frame_active,
                                          frame_start, frame_end, partial_word, bit_cnt}), 0);

        for (int i = 0; i < 5; i++) begin
            take_snap();
            run_frame(vecs[i].mode, vecs[i].pulses, vecs[i].lvl);
            check_frame($sformatf("vec%0d", i), vecs[i].pulses, vecs[i].shifts, vecs[i].words,
                        1, 1, vecs[i].partial, vecs[i].endcnt);
        end

        // cs_n held low through reset release: no frame until cs_n goes high then low
        sysrst = 1'b0;
        cs_n   = 1'b0;
        sclk   = 1'b0;
        mode   = 2'b00;
        idle(3);
        take_snap();
        sysrst = 1'b1;
        idle(4);
        pulses(1'b0, 4);
        check_frame("cs_low_reset", 0, 0, 0, 0, 0, 0, 0);
        cs_n = 1'b1;
        idle(6);
        take_snap();
        run_frame(2'b00, 2, 1'b1);
        check_frame("rearmed", 2, 2, 0, 1, 1, 1, 2);

        // cs_n rise together with a sample edge: edge dropped, frame_end wins
        take_snap();
        exp_lvl = 1'b1;
        open_frame(2'b00);
        pulses(1'b0, 3);
        cs_n = 1'b1;
        sclk = 1'b1;
        idle(10);
        sclk = 1'b0;
        idle(5);
        check_frame("cs_rise_edge", 3, 3, 0, 1, 1, 1, 3);

        // cs_n fall together with a sample edge: that edge dropped, its fall still shifts
        mode = 2'b00;
        sclk = 1'b0;
        idle(8);
        take_snap();
        cs_n = 1'b0;
        sclk = 1'b1;
        idle(6);
        sclk = 1'b0;
        idle(6);
        pulses(1'b0, 2);
        close_frame();
        check_frame("cs_fall_edge", 2, 3, 0, 1, 1, 1, 2);

        // mode change mid-frame takes effect only at the next frame
        take_snap();
        exp_lvl = 1'b1;
        open_frame(2'b00);
        pulses(1'b0, 2);
        mode = 2'b01;
        pulses(1'b0, 2);
        close_frame();
        check_frame("mode_change", 4, 4, 0, 1, 1, 1, 4);
        take_snap();
        run_frame(2'b01, 2, 1'b0);
        check_frame("new_mode", 2, 2, 0, 1, 1, 1, 2);

        // reset mid-frame: outputs clear at once, no frame_end, next frame counts from 0
        take_snap();
        exp_lvl = 1'b1;
        open_frame(2'b00);
        pulses(1'b0, 3);
        check("bit_cnt before mid-frame reset", int'(bit_cnt), 3);
        sysrst = 1'b0;
        #1;
        check("outputs during mid-frame reset", int'({sample_stb, shift_stb, word_done, frame_active,
                                                     frame_start, frame_end, partial_word, bit_cnt}), 0);
        idle(3);
        sysrst = 1'b1;
        idle(5);
        check_frame("reset_mid", 3, 3, 0, 1, 0, 0, 0);
        cs_n = 1'b1;
        idle(6);
        take_snap();
        run_frame(2'b00, 2, 1'b1);
        check_frame("after_reset", 2, 2, 0, 1, 1, 1, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
